// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative divider among NREQ requesters.
//
// Arbitration is round-robin: the first valid requester at or after rr_ptr wins. The accepted
// operands are held on div_* while the divider runs. The result is returned on a single
// back-pressured response channel. Only one division is in flight at a time.
//
// Optional feature: define DIV_ARB_ZERO_BYPASS_EN to answer zero-divisor requests directly.
// Such a response has quotient all ones, remainder = dividend and rsp_dbz_o = 1, and the
// divider is not started.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   per-requester handshake (ready is one-hot or zero)
//   req_sign_i                  per-requester signed (1) / unsigned (0) select
//   req_dividend_i/divisor_i    packed operands, requester i at [i*WIDTH +: WIDTH]
//   div_start_o                 one-cycle launch pulse to the divider
//   div_sign_o/dividend_o/divisor_o  latched operands to the divider
//   div_quotient_i/remainder_i  divider results, valid with div_ready_i
//   div_ready_i                 divider one-cycle done pulse
//   rsp_valid_o / rsp_ready_i   response handshake
//   rsp_id_o/quotient_o/remainder_o/dbz_o  response payload
//   busy_o                      high whenever the FSM is not idle
`timescale 1ns/1ps

module div_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ-1:0]         req_sign_i,
  input  logic [NREQ*WIDTH-1:0]   req_dividend_i,
  input  logic [NREQ*WIDTH-1:0]   req_divisor_i,
  output logic                    div_start_o,
  output logic                    div_sign_o,
  output logic [WIDTH-1:0]        div_dividend_o,
  output logic [WIDTH-1:0]        div_divisor_o,
  input  logic [WIDTH-1:0]        div_quotient_i,
  input  logic [WIDTH-1:0]        div_remainder_i,
  input  logic                    div_ready_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IDW-1:0]          rsp_id_o,
  output logic [WIDTH-1:0]        rsp_quotient_o,
  output logic [WIDTH-1:0]        rsp_remainder_o,
  output logic                    rsp_dbz_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;
  // One extra bit so rr_ptr + offset can be wrapped without overflow.
  typedef logic [IDW:0] idx_t;

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic             div_start_q;
  logic             div_sign_q;
  logic [WIDTH-1:0] div_dividend_q;
  logic [WIDTH-1:0] div_divisor_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_quotient_q;
  logic [WIDTH-1:0] rsp_remainder_q;
  logic             busy_q;
`ifdef DIV_ARB_ZERO_BYPASS_EN
  logic             rsp_dbz_q;
`endif

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  idx_t             cand;
  idx_t             ptr_inc;
  logic [IDW-1:0]   next_ptr;
  logic             sel_sign;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;

  // Round-robin search: scan offsets 0..NREQ-1 from rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + idx_t'(k);
      if (cand >= idx_t'(NREQ)) begin
        cand = cand - idx_t'(NREQ);
      end
      if (!grant_found && req_valid_i[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_inc  = {1'b0, grant_idx} + idx_t'(1);
    next_ptr = (ptr_inc == idx_t'(NREQ)) ? '0 : ptr_inc[IDW-1:0];
  end

  assign sel_sign     = req_sign_i[grant_idx];
  assign sel_dividend = req_dividend_i[grant_idx*WIDTH +: WIDTH];
  assign sel_divisor  = req_divisor_i[grant_idx*WIDTH +: WIDTH];

  // The handshake completes in the IDLE cycle itself, so ready is combinational.
  assign req_ready_o = (state_q == StIdle && grant_found) ? (NREQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      rr_ptr_q        <= '0;
      div_start_q     <= 1'b0;
      div_sign_q      <= 1'b0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= '0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
      busy_q          <= 1'b0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
      rsp_dbz_q       <= 1'b0;
`endif
    end else begin
      div_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            div_sign_q     <= sel_sign;
            div_dividend_q <= sel_dividend;
            div_divisor_q  <= sel_divisor;
            rsp_id_q       <= grant_idx;
            rr_ptr_q       <= next_ptr;
            busy_q         <= 1'b1;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            if (sel_divisor == '0) begin
              rsp_quotient_q  <= '1;
              rsp_remainder_q <= sel_dividend;
              rsp_dbz_q       <= 1'b1;
              rsp_valid_q     <= 1'b1;
              state_q         <= StResp;
            end else begin
              rsp_dbz_q   <= 1'b0;
              div_start_q <= 1'b1;
              state_q     <= StLaunch;
            end
`else
            div_start_q <= 1'b1;
            state_q     <= StLaunch;
`endif
          end
        end
        StLaunch: begin
          state_q <= StWait;
        end
        StWait: begin
          // div_ready in any other state is stale and deliberately dropped.
          if (div_ready_i) begin
            rsp_quotient_q  <= div_quotient_i;
            rsp_remainder_q <= div_remainder_i;
            rsp_valid_q     <= 1'b1;
            state_q         <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign div_start_o     = div_start_q;
  assign div_sign_o      = div_sign_q;
  assign div_dividend_o  = div_dividend_q;
  assign div_divisor_o   = div_divisor_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_id_o        = rsp_id_q;
  assign rsp_quotient_o  = rsp_quotient_q;
  assign rsp_remainder_o = rsp_remainder_q;
  assign busy_o          = busy_q;
`ifdef DIV_ARB_ZERO_BYPASS_EN
  assign rsp_dbz_o       = rsp_dbz_q;
`else
  assign rsp_dbz_o       = 1'b0;
`endif

endmodule
